// File: rtl/fp_scale_pkg.sv
// fp_scale_pkg: shared widths, exponent helpers and result classes for the
// complex power-of-two scaler.
package fp_scale_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    // All-ones exponent code reserved for Inf/NaN
    function automatic int e_max_of(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF-1:0] man;
    } fp_word_t;

    typedef enum logic [2:0] {
        ZERO,
        SPECIAL,
        UF,
        OF,
        NORM
    } fp_class_t;

endpackage

// File: rtl/fp_pow2_lane.sv
// fp_pow2_lane: combinational classify/adjust of one float lane, given the
// already-extended new exponent. Zero/subnormal inputs are flushed, Inf/NaN
// pass through, out-of-range results saturate to signed zero or signed Inf.
module fp_pow2_lane
    import fp_scale_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   sign,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic [MAN_W-1:0]       man,
    input  logic signed [EXP_W+1:0] e_new,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   uf,
    output logic                   of
);

    localparam logic [EXP_W-1:0]        E_MAX   = EXP_W'(e_max_of(EXP_W));
    localparam logic signed [EXP_W+1:0] E_MAX_X = (EXP_W+2)'(e_max_of(EXP_W));
    localparam logic signed [EXP_W+1:0] E_ZERO  = '0;

    fp_class_t cls;

    // Decide which rule applies; input specials take precedence over range checks
    always_comb begin
        cls = NORM;
        if (exp_in == '0) begin
            cls = ZERO;
        end else if (exp_in == E_MAX) begin
            cls = SPECIAL;
        end else if (e_new <= E_ZERO) begin
            cls = UF;
        end else if (e_new >= E_MAX_X) begin
            cls = OF;
        end
    end

    // Build the output word and flags for the chosen class
    always_comb begin
        result = {sign, exp_in, man};
        uf     = 1'b0;
        of     = 1'b0;
        case (cls)
            ZERO:    result = {sign, {(EXP_W+MAN_W){1'b0}}};
            SPECIAL: result = {sign, exp_in, man};
            UF: begin
                result = {sign, {(EXP_W+MAN_W){1'b0}}};
                uf     = 1'b1;
            end
            OF: begin
                result = {sign, E_MAX, {MAN_W{1'b0}}};
                of     = 1'b1;
            end
            NORM:    result = {sign, e_new[EXP_W-1:0], man};
            default: result = {sign, exp_in, man};
        endcase
    end

endmodule

// File: rtl/fp_cplx_pow2_scale.sv
// fp_cplx_pow2_scale: two-stage pipelined complex scaler by 2^shift with
// valid/ready flow control. S1 captures fields and the extended exponent,
// S2 captures the classified result and per-lane flags.
// Optional status counters are enabled with macro FP_SCALE_STATUS_CNT_EN.
module fp_cplx_pow2_scale
    import fp_scale_pkg::*;
#(
    parameter int EXP_W   = EXP_W_DEF,
    parameter int MAN_W   = MAN_W_DEF,
    parameter int SHIFT_W = 6,
    localparam int W      = 1 + EXP_W + MAN_W
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef FP_SCALE_STATUS_CNT_EN
    input  logic               cnt_clr,
    output logic [15:0]        uf_cnt,
    output logic [15:0]        of_cnt,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_re,
    input  logic [W-1:0]       in_img,
    input  logic [SHIFT_W-1:0] in_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_re,
    output logic [W-1:0]       out_img,
    output logic [1:0]         out_uf,
    output logic [1:0]         out_of
);

    localparam int XW = EXP_W + 2;

    logic s1_valid, s2_valid, s1_en, s2_en, accept;

    logic                 s1_re_sign, s1_img_sign;
    logic [EXP_W-1:0]     s1_re_exp, s1_img_exp;
    logic [MAN_W-1:0]     s1_re_man, s1_img_man;
    logic signed [XW-1:0] s1_re_enew, s1_img_enew;

    logic signed [XW-1:0] shift_x, re_enew_d, img_enew_d;
    logic [W-1:0]         re_res, img_res;
    logic                 re_uf, re_of, img_uf, img_of;

    assign s2_en     = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign in_ready  = s1_en;
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_valid;

    assign shift_x    = {{(XW-SHIFT_W){in_shift[SHIFT_W-1]}}, in_shift};
    assign re_enew_d  = signed'({2'b00, in_re[W-2:MAN_W]}) + shift_x;
    assign img_enew_d = signed'({2'b00, in_img[W-2:MAN_W]}) + shift_x;

    // S1: capture the sample fields and the widened exponent sum on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_re_sign  <= 1'b0;
            s1_re_exp   <= '0;
            s1_re_man   <= '0;
            s1_re_enew  <= '0;
            s1_img_sign <= 1'b0;
            s1_img_exp  <= '0;
            s1_img_man  <= '0;
            s1_img_enew <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_re_sign  <= in_re[W-1];
                s1_re_exp   <= in_re[W-2:MAN_W];
                s1_re_man   <= in_re[MAN_W-1:0];
                s1_re_enew  <= re_enew_d;
                s1_img_sign <= in_img[W-1];
                s1_img_exp  <= in_img[W-2:MAN_W];
                s1_img_man  <= in_img[MAN_W-1:0];
                s1_img_enew <= img_enew_d;
            end
        end
    end

    fp_pow2_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lane_re (
        .sign   (s1_re_sign),
        .exp_in (s1_re_exp),
        .man    (s1_re_man),
        .e_new  (s1_re_enew),
        .result (re_res),
        .uf     (re_uf),
        .of     (re_of)
    );

    fp_pow2_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_lane_img (
        .sign   (s1_img_sign),
        .exp_in (s1_img_exp),
        .man    (s1_img_man),
        .e_new  (s1_img_enew),
        .result (img_res),
        .uf     (img_uf),
        .of     (img_of)
    );

    // S2: register classified results; held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_re   <= '0;
            out_img  <= '0;
            out_uf   <= '0;
            out_of   <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_re  <= re_res;
                out_img <= img_res;
                out_uf  <= {img_uf, re_uf};
                out_of  <= {img_of, re_of};
            end
        end
    end

`ifdef FP_SCALE_STATUS_CNT_EN
    function automatic logic [15:0] sat_add(input logic [15:0] cnt,
                                            input logic a, input logic b);
        logic [16:0] sum;
        sum = {1'b0, cnt} + 17'(a) + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Event counters: count flagged lanes as each result lands in S2, clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_cnt <= '0;
            of_cnt <= '0;
        end else if (cnt_clr) begin
            uf_cnt <= '0;
            of_cnt <= '0;
        end else if (s2_en && s1_valid) begin
            uf_cnt <= sat_add(uf_cnt, re_uf, img_uf);
            of_cnt <= sat_add(of_cnt, re_of, img_of);
        end
    end
`endif

endmodule

// File: tb/tb_fp_cplx_pow2_scale.sv
// tb_fp_cplx_pow2_scale: directed and randomized checks of the complex
// power-of-two scaler against a value-level reference model and a queue of
// in-flight samples. Also covers counters when FP_SCALE_STATUS_CNT_EN is set.
module tb_fp_cplx_pow2_scale;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] img;
        logic [1:0]  uf;
        logic [1:0]  of;
    } res_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_re, in_img, out_re, out_img;
    logic [5:0]  in_shift;
    logic [1:0]  out_uf, out_of;
`ifdef FP_SCALE_STATUS_CNT_EN
    logic        cnt_clr;
    logic [15:0] uf_cnt, of_cnt;
`endif

    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    res_t q[$];
    int   born[$];

    fp_cplx_pow2_scale dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FP_SCALE_STATUS_CNT_EN
        .cnt_clr   (cnt_clr),
        .uf_cnt    (uf_cnt),
        .of_cnt    (of_cnt),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_img    (in_img),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_img   (out_img),
        .out_uf    (out_uf),
        .out_of    (out_of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
            $error("[TB] check %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Value-level rule for one lane: returns {uf, of, word}
    function automatic logic [33:0] ref_lane(input logic [31:0] w, input int sh);
        int   e;
        int   en;
        logic s;
        logic [7:0] e8;
        s  = w[31];
        e  = int'(w[30:23]);
        en = e + sh;
        if (e == 0)    return {2'b00, s, 31'd0};
        if (e == 255)  return {2'b00, w};
        if (en <= 0)   return {2'b10, s, 31'd0};
        if (en >= 255) return {2'b01, s, 8'hFF, 23'd0};
        e8 = 8'(en);
        return {2'b00, s, e8, w[22:0]};
    endfunction

    function automatic res_t model(input logic [31:0] re, input logic [31:0] img,
                                   input logic [5:0] sh);
        logic [33:0] r, i;
        int          shv;
        res_t        res;
        shv = $signed(sh);
        r = ref_lane(re, shv);
        i = ref_lane(img, shv);
        res.re  = r[31:0];
        res.img = i[31:0];
        res.uf  = {i[33], r[33]};
        res.of  = {i[32], r[32]};
        return res;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [7:0] e;
        case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'($urandom_range(1, 3));
            3:       e = 8'($urandom_range(252, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // One clock: drive at negedge, check outputs against the in-flight queue,
    // then update the queue with whatever handshakes the next posedge performs
    task automatic applyStimulus(input logic v, input logic [31:0] re, input logic [31:0] img,
                                 input logic [5:0] sh, input logic rdy,
                                 input logic use_lit, input res_t lit, output logic accepted);
        logic fire_in, fire_out, exp_ov;
        @(negedge clk);
        in_valid  = v;
        in_re     = re;
        in_img    = img;
        in_shift  = sh;
        out_ready = rdy;
        #1;
        chk("in_ready", 68'(in_ready), 68'((q.size() < 2) || rdy));
        exp_ov = (q.size() > 0) && (cyc - born[0] >= 1);
        chk("out_valid", 68'(out_valid), 68'(exp_ov));
        if (out_valid && q.size() > 0)
            chk("out_data", {out_re, out_img, out_uf, out_of}, q[0]);
        fire_in  = v && in_ready;
        fire_out = out_valid && out_ready;
        @(posedge clk);
        cyc++;
        if (fire_out && q.size() > 0) begin
            void'(q.pop_front());
            void'(born.pop_front());
        end
        if (fire_in) begin
            q.push_back(use_lit ? lit : model(re, img, sh));
            born.push_back(cyc);
        end
        accepted = fire_in;
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        res_t none;
        none = '0;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 32'd0, 6'd0, rdy, 1'b0, none, acc);
    endtask

    task automatic checkOutput(input string tag);
        int budget;
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            idle(1, 1'b1);
            budget++;
        end
        chk(tag, 68'(q.size()), 68'd0);
    endtask

    initial begin
        logic acc;
        res_t none;
        res_t lit;
        logic pat [4];
        int   sent;
        none = '0;
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_img = '0; in_shift = '0; out_ready = 1'b0;
`ifdef FP_SCALE_STATUS_CNT_EN
        cnt_clr = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 68'(out_valid), 68'd0);
        chk("rst_in_ready", 68'(in_ready), 68'd1);
        chk("rst_outputs", {out_re, out_img, out_uf, out_of}, 68'd0);
        rst_n = 1'b1;

        // 1.0 / 8 on both signs with exact two-cycle latency
        lit = '{re: 32'h3E000000, img: 32'hBE000000, uf: 2'b00, of: 2'b00};
        applyStimulus(1'b1, 32'h3F800000, 32'hBF800000, 6'h3D, 1'b1, 1'b1, lit, acc);
        idle(3, 1'b1);

        // Dual-lane underflow to signed zero
        lit = '{re: 32'h00000000, img: 32'h80000000, uf: 2'b11, of: 2'b00};
        applyStimulus(1'b1, 32'h00800000, 32'h80800000, 6'h3F, 1'b1, 1'b1, lit, acc);
        // Real overflow to Inf while the NaN imaginary lane passes through
        lit = '{re: 32'h7F800000, img: 32'h7FC00000, uf: 2'b00, of: 2'b01};
        applyStimulus(1'b1, 32'h7F000000, 32'h7FC00000, 6'h01, 1'b1, 1'b1, lit, acc);
        // Zero shift pass-through, and the last exponent below Inf
        lit = '{re: 32'h40490FDB, img: 32'hC0490FDB, uf: 2'b00, of: 2'b00};
        applyStimulus(1'b1, 32'h40490FDB, 32'hC0490FDB, 6'h00, 1'b1, 1'b1, lit, acc);
        lit = '{re: 32'h7F7FFFFF, img: 32'h00800001, uf: 2'b00, of: 2'b00};
        applyStimulus(1'b1, 32'h7EFFFFFF, 32'h00800001, 6'h01, 1'b1, 1'b0, none, acc);
        applyStimulus(1'b1, 32'h7E800000, 32'h00800001, 6'h00, 1'b1, 1'b0, none, acc);
        // Subnormals flush silently even when shifted up
        lit = '{re: 32'h00000000, img: 32'h80000000, uf: 2'b00, of: 2'b00};
        applyStimulus(1'b1, 32'h00000001, 32'h80400000, 6'h05, 1'b1, 1'b1, lit, acc);
        checkOutput("drain_directed");

        // Backpressure: 8 samples with out_ready cycling 1,0,0,1
        sent = 0;
        for (int k = 0; k < 64 && (sent < 8 || q.size() > 0); k++) begin
            applyStimulus(sent < 8, rand_word(), rand_word(), 6'($urandom_range(0, 63)),
                          pat[k % 4], 1'b0, none, acc);
            if (acc) sent++;
        end
        chk("bp_sent", 68'(sent), 68'd8);
        checkOutput("drain_bp");

        // Randomized traffic with random valid and ready
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_word(), rand_word(),
                          6'($urandom_range(0, 63)), $urandom_range(0, 9) < 7,
                          1'b0, none, acc);
        end
        checkOutput("drain_rand");

        // Reset with two samples in flight
        applyStimulus(1'b1, 32'h3F800000, 32'h40000000, 6'h02, 1'b0, 1'b0, none, acc);
        applyStimulus(1'b1, 32'h40400000, 32'h40800000, 6'h02, 1'b0, 1'b0, none, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", 68'(out_valid), 68'd0);
        chk("midrst_outputs", {out_re, out_img, out_uf, out_of}, 68'd0);
        q.delete();
        born.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4, 1'b1);

`ifdef FP_SCALE_STATUS_CNT_EN
        // Counters: three dual-lane underflows, then clear racing an underflow
        cnt_clr = 1'b1;
        idle(1, 1'b1);
        cnt_clr = 1'b0;
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 32'h00800000, 32'h80800000, 6'h3F, 1'b1, 1'b0, none, acc);
        idle(3, 1'b1);
        chk("uf_cnt_6", 68'(uf_cnt), 68'd6);
        chk("of_cnt_0", 68'(of_cnt), 68'd0);
        applyStimulus(1'b1, 32'h00800000, 32'h80800000, 6'h3F, 1'b1, 1'b0, none, acc);
        cnt_clr = 1'b1;
        idle(1, 1'b1);
        cnt_clr = 1'b0;
        idle(2, 1'b1);
        chk("uf_cnt_clr", 68'(uf_cnt), 68'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fp_cplx_pow2_scale.md
Name: fp_cplx_pow2_scale

Overview:
- Pipelined complex floating-point power-of-two scaler: multiplies both real and imaginary parts by 2^shift by adjusting the exponent only.
- `shift` is signed and supplied per sample. Negative values divide, e.g. -3 is divide by 8.
- Handles zero, subnormal, Inf/NaN, underflow and overflow.
- Sits between FFT butterfly stages as the normalisation/scaling step, with valid/ready flow control.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width. Word width W = 1+EXP_W+MAN_W.
- SHIFT_W, 6, width of signed shift input. Range -32..+31 at default.

Ports:
- clk  in  1  clock; all state rises on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept input this cycle.
- in_re  in  W  real part, IEEE-754-style.
- in_img  in  W  imaginary part.
- in_shift  in  SHIFT_W  signed two's-complement exponent delta.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_re  out  W  scaled real part.
- out_img  out  W  scaled imaginary part.
- out_uf  out  2  underflow flag per lane: [0]=re, [1]=img.
- out_of  out  2  overflow flag per lane: [0]=re, [1]=img.

Behaviour:
- Reset state: all outputs 0, both stage valids 0. in_ready is 1 after reset because it is combinational from empty stages. Reset asserted mid-operation discards in-flight samples; no output pulse follows.
- Pipeline: two register stages, S1 and S2. Latency is exactly 2 cycles from accept (in_valid&&in_ready) to out_valid, with no stall.
- S1 registers sign, exponent, mantissa and the computed extended exponent e_new = e + sext(shift), width EXP_W+2, signed.
- S2 registers the classified result and the flags.
- Flow control:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en
- Full throughput is 1 sample/cycle. Bubbles collapse.
- Data and flags hold stable while out_valid && !out_ready.
- Per-lane classification, with E_MAX = 2^EXP_W-1:
  - e == 0 (zero or subnormal): output signed zero, exp=0, man=0. Flush; no flags.
  - e == E_MAX (Inf/NaN): pass the word unchanged. No flags.
  - e_new <= 0: signed zero, uf=1.
  - e_new >= E_MAX: signed Inf (exp=E_MAX, man=0), of=1.
  - Otherwise: sign and mantissa unchanged, exponent = e_new[EXP_W-1:0].
- shift == 0 is an exact pass-through for normal values.
- The two lanes are independent; both flags may assert in the same cycle.
- No rounding ever occurs.

Optional Feature:
- Macro FP_SCALE_STATUS_CNT_EN.
- When defined, adds these ports:
  - cnt_clr  in  1  synchronous clear.
  - uf_cnt  out  16  underflow event count.
  - of_cnt  out  16  overflow event count.
- Counting rules:
  - Counters increment when S2 loads a result (s2_en && s1_valid).
  - Each increments by the number of lanes flagged (0, 1 or 2).
  - Counters saturate at 16'hFFFF.
- cnt_clr has priority over an increment in the same cycle. Reset clears both counters.
- When the macro is undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fp_scale_pkg holds:
  - EXP_W/MAN_W defaults;
  - a localparam function computing E_MAX;
  - a typedef for the packed float {sign, exp, man};
  - a class enum {ZERO, SPECIAL, UF, OF, NORM}.
- One sub-module, fp_pow2_lane: the combinational classify/adjust for one lane, instantiated twice (re, img).
- Pipeline registers and handshake stay in the top module.

Test Plan:
- 1.0 scaled by 1/8: in_re=0x3F800000, in_img=0xBF800000, shift=-3, out_ready=1. Expect out_re=0x3E000000, out_img=0xBE000000 exactly 2 cycles later, flags 0.
- Underflow: in_re=0x00800000, in_img=0x80800000, shift=-1. Expect out_re=0x00000000, out_img=0x80000000, out_uf=2'b11.
- Overflow and special: in_re=0x7F000000, shift=+1, expect 0x7F800000 with out_of[0]=1. In the same sample in_img=0x7FC00000 (NaN), expect it passed unchanged with no img flag.
- Backpressure: stream 8 samples with out_ready toggling 1,0,0,1. Expect no loss or duplication, order preserved, out data stable while stalled, and in_ready=0 only when both stages are full and out_ready=0.
- Reset mid-stream: deassert rst_n with 2 samples in flight. Expect out_valid=0 immediately and all outputs 0, with no stale output after release.
- With FP_SCALE_STATUS_CNT_EN: 3 dual-lane underflows, then cnt_clr asserted together with an underflow. Expect uf_cnt to reach 6, then read 0.
